// File: rtl/memory_access_unit_pkg.sv
// Shared definitions for the memory access stage: FSM states, access width codes
// and per-width lane constants.
package memory_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } mau_state_e;

    localparam logic [1:0] MEM_WIDTH_BYTE  = 2'd0;
    localparam logic [1:0] MEM_WIDTH_HALF  = 2'd1;
    localparam logic [1:0] MEM_WIDTH_WORD  = 2'd2;
    localparam logic [1:0] MEM_WIDTH_DWORD = 2'd3;

    function automatic logic [7:0] size_mask(input logic [1:0] width);
        case (width)
            MEM_WIDTH_BYTE: size_mask = 8'h01;
            MEM_WIDTH_HALF: size_mask = 8'h03;
            MEM_WIDTH_WORD: size_mask = 8'h0F;
            default:        size_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic [3:0] size_bytes(input logic [1:0] width);
        case (width)
            MEM_WIDTH_BYTE: size_bytes = 4'd1;
            MEM_WIDTH_HALF: size_bytes = 4'd2;
            MEM_WIDTH_WORD: size_bytes = 4'd4;
            default:        size_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_unit_load_data_extend.sv
// Truncates right-aligned load data to the access width and sign- or zero-extends it.
module load_data_extend
    import memory_access_unit_pkg::*;
(
    input  logic [63:0] raw_data,
    input  logic [1:0]  width,
    input  logic        zero_ext,
    output logic [63:0] ext_data
);

    always_comb begin
        ext_data = raw_data;
        case (width)
            MEM_WIDTH_BYTE: ext_data = zero_ext ? {56'd0, raw_data[7:0]}
                                                : {{56{raw_data[7]}}, raw_data[7:0]};
            MEM_WIDTH_HALF: ext_data = zero_ext ? {48'd0, raw_data[15:0]}
                                                : {{48{raw_data[15]}}, raw_data[15:0]};
            MEM_WIDTH_WORD: ext_data = zero_ext ? {32'd0, raw_data[31:0]}
                                                : {{32{raw_data[31]}}, raw_data[31:0]};
            default:        ext_data = raw_data;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// Memory access pipeline stage: issues one or two dword-aligned beats per load/store
// over a req/gnt/rvalid port and returns extended load data or the ALU result.
module memory_access_unit
    import memory_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic        mem_read_signal_in,
    input  logic        mem_write_signal_in,
    input  logic [2:0]  width_data_signal_in,
    input  logic [63:0] alu_result_in,
    input  logic [63:0] rs2_value_in,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [63:0] dmem_addr_out,
    output logic [7:0]  dmem_be_out,
    output logic [63:0] dmem_wdata_out,
    input  logic        dmem_gnt_in,
    input  logic        dmem_rvalid_in,
    input  logic [63:0] dmem_rdata_in,
    input  logic        dmem_err_in,
    output logic        valid_out,
    output logic [63:0] wr_data_out,
    output logic        fault_signal_out
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    mau_state_e state_q, state_d;

    logic [63:0]      addr_q, rs2_q, rdata0_q, result_q;
    logic [2:0]       width_q;
    logic             load_q, store_q, beat_q, fault_q;
    logic [CNT_W-1:0] cnt_q;

    logic accept, cnt_clr, cnt_inc, resp_next_beat, resp_final, resp_fault;

    logic [2:0]  off;
    logic [5:0]  shift;
    logic [6:0]  rshift;
    logic [7:0]  mask;
    logic        split;
    logic [63:0] base_addr, lo_data, hi_data, raw_load, ext_load;

    assign off       = addr_q[2:0];
    assign shift     = {off, 3'b000};
    assign rshift    = 7'd64 - {1'b0, shift};
    assign mask      = size_mask(width_q[1:0]);
    assign split     = ({1'b0, off} + size_bytes(width_q[1:0])) > 4'd8;
    assign base_addr = {addr_q[63:3], 3'b000};

    // Beat 0 data is latched; on the closing response the live bus data is the upper beat.
    assign lo_data  = beat_q ? rdata0_q : dmem_rdata_in;
    assign hi_data  = beat_q ? dmem_rdata_in : '0;
    assign raw_load = (lo_data >> shift) | (hi_data << rshift);

    load_data_extend u_extend (
        .raw_data (raw_load),
        .width    (width_q[1:0]),
        .zero_ext (width_q[2]),
        .ext_data (ext_load)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        cnt_clr        = 1'b0;
        cnt_inc        = 1'b0;
        resp_next_beat = 1'b0;
        resp_final     = 1'b0;
        resp_fault     = 1'b0;
        case (state_q)
            IDLE: if (valid_in) begin
                accept  = 1'b1;
                state_d = (mem_read_signal_in || mem_write_signal_in) ? REQ : DONE;
            end
            REQ: if (dmem_gnt_in) begin
                cnt_clr = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (dmem_rvalid_in) begin
                    if (dmem_err_in) begin
                        resp_fault = 1'b1;
                        state_d    = DONE;
                    end else if (split && !beat_q) begin
                        resp_next_beat = 1'b1;
                        state_d        = REQ;
                    end else begin
                        resp_final = 1'b1;
                        state_d    = DONE;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_fault = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_q   <= '0;
            rs2_q    <= '0;
            rdata0_q <= '0;
            result_q <= '0;
            width_q  <= '0;
            load_q   <= 1'b0;
            store_q  <= 1'b0;
            beat_q   <= 1'b0;
            fault_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                addr_q   <= alu_result_in;
                rs2_q    <= rs2_value_in;
                width_q  <= width_data_signal_in;
                load_q   <= mem_read_signal_in;
                store_q  <= mem_write_signal_in;
                beat_q   <= 1'b0;
                fault_q  <= 1'b0;
                result_q <= (mem_read_signal_in || mem_write_signal_in) ? '0 : alu_result_in;
            end
            if (cnt_clr) cnt_q <= '0;
            if (cnt_inc) cnt_q <= cnt_q + 1'b1;
            if (resp_next_beat) begin
                rdata0_q <= dmem_rdata_in;
                beat_q   <= 1'b1;
            end
            if (resp_final) result_q <= load_q ? ext_load : '0;
            if (resp_fault) begin
                fault_q  <= 1'b1;
                result_q <= '0;
            end
        end
    end

    assign ready_out        = (state_q == IDLE);
    assign dmem_req_out     = (state_q == REQ);
    assign dmem_we_out      = dmem_req_out && store_q;
    assign dmem_addr_out    = !dmem_req_out ? '0 : (beat_q ? base_addr + 64'd8 : base_addr);
    assign dmem_be_out      = !dmem_req_out ? '0 : (beat_q ? (mask >> (4'd8 - {1'b0, off})) : 8'(mask << off));
    assign dmem_wdata_out   = !dmem_req_out ? '0 : (beat_q ? (rs2_q >> rshift) : (rs2_q << shift));
    assign valid_out        = (state_q == DONE);
    assign wr_data_out      = result_q;
    assign fault_signal_out = valid_out && fault_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed self-checking bench for memory_access_unit with an inline bus responder.
module tb_memory_access_unit;

    localparam int unsigned TMO = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, ready_out;
    logic        mem_rd, mem_wr;
    logic [2:0]  width;
    logic [63:0] alu_result, rs2;
    logic        req, we;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic        gnt, rvalid, err;
    logic [63:0] rdata;
    logic        valid_out;
    logic [63:0] wr_data;
    logic        fault;

    int checks = 0;
    int errors = 0;

    // Results of the most recent transaction.
    int          r_cycles;
    int          r_beats;
    logic [63:0] r_result;
    logic        r_fault;
    logic [63:0] r_addr  [2];
    logic [7:0]  r_be    [2];
    logic [63:0] r_wdata [2];
    logic        r_we    [2];

    memory_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_in               (clk),
        .rst_n_in             (rst_n),
        .valid_in             (valid_in),
        .ready_out            (ready_out),
        .mem_read_signal_in   (mem_rd),
        .mem_write_signal_in  (mem_wr),
        .width_data_signal_in (width),
        .alu_result_in        (alu_result),
        .rs2_value_in         (rs2),
        .dmem_req_out         (req),
        .dmem_we_out          (we),
        .dmem_addr_out        (addr),
        .dmem_be_out          (be),
        .dmem_wdata_out       (wdata),
        .dmem_gnt_in          (gnt),
        .dmem_rvalid_in       (rvalid),
        .dmem_rdata_in        (rdata),
        .dmem_err_in          (err),
        .valid_out            (valid_out),
        .wr_data_out          (wr_data),
        .fault_signal_out     (fault)
    );

    always #5 clk = ~clk;

    // Issues one op at a negedge and plays the memory; r_cycles counts negedges after acceptance.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] w,
                          input logic [63:0] a, input logic [63:0] d,
                          input logic [63:0] rd0, input logic [63:0] rd1,
                          input int gnt_wait, input int rv_wait,
                          input logic err0, input logic no_resp);
        bit pending = 0;
        int gw = 0;
        int rw = 0;
        r_cycles = 0;
        r_beats  = 0;
        r_result = 'x;
        r_fault  = 1'bx;
        for (int i = 0; i < 2; i++) begin
            r_addr[i] = '0; r_be[i] = '0; r_wdata[i] = '0; r_we[i] = 1'b0;
        end
        valid_in = 1'b1; mem_rd = rd; mem_wr = wr; width = w; alu_result = a; rs2 = d;
        @(posedge clk);
        #1 valid_in = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = '0;
            if (valid_out) begin
                r_cycles = k;
                r_result = wr_data;
                r_fault  = fault;
                break;
            end
            if (pending) begin
                if (rw == rv_wait) begin
                    rvalid  = 1'b1;
                    rdata   = (r_beats == 1) ? rd0 : rd1;
                    err     = err0 && (r_beats == 1);
                    pending = 0;
                end else rw++;
            end else if (req) begin
                if (gw == gnt_wait) begin
                    if (r_beats < 2) begin
                        r_addr[r_beats] = addr; r_be[r_beats] = be;
                        r_wdata[r_beats] = wdata; r_we[r_beats] = we;
                    end
                    r_beats++;
                    gnt     = 1'b1;
                    pending = !no_resp;
                    gw = 0; rw = 0;
                end else gw++;
            end
        end
        if (r_cycles == 0) $display("FAIL op_bound: valid_out never seen within 200 cycles");
        @(negedge clk);
        gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = '0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_out); end
        checks++; if ({req, we, valid_out, fault} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 0000", {req, we, valid_out, fault}); end
        checks++; if ({addr, be, wdata, wr_data} !== '0) begin errors++; $display("FAIL reset_data: addr %h be %h wdata %h wr %h want all 0", addr, be, wdata, wr_data); end
    endtask

    task automatic test_alu_passthrough;
        // Stray bus handshakes while idle must be ignored.
        gnt = 1'b1; rvalid = 1'b1; rdata = 64'hFFFF;
        @(negedge clk);
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        checks++; if (valid_out !== 1'b0 || ready_out !== 1'b1) begin errors++; $display("FAIL stray_idle: valid %b ready %b want 0 1", valid_out, ready_out); end
        run_op(0, 0, 3'd3, 64'h1234, 64'h0, '0, '0, 0, 0, 0, 0);
        checks++; if (r_cycles !== 1) begin errors++; $display("FAIL alu_latency: got %0d want 1", r_cycles); end
        checks++; if (r_result !== 64'h1234) begin errors++; $display("FAIL alu_data: got %h want 1234", r_result); end
        checks++; if (r_beats !== 0) begin errors++; $display("FAIL alu_noreq: got %0d beats want 0", r_beats); end
    endtask

    task automatic test_byte_loads;
        run_op(1, 0, 3'b000, 64'h1003, '0, 64'h0000_0000_8000_0000, '0, 0, 0, 0, 0);
        checks++; if (r_be[0] !== 8'h08 || r_addr[0] !== 64'h1000 || r_we[0] !== 1'b0) begin errors++; $display("FAIL lb_beat: be %h addr %h we %b want 08 1000 0", r_be[0], r_addr[0], r_we[0]); end
        checks++; if (r_result !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_data: got %h want ffffffffffffff80", r_result); end
        checks++; if (r_cycles !== 3) begin errors++; $display("FAIL lb_latency: got %0d want 3", r_cycles); end
        run_op(1, 0, 3'b100, 64'h1003, '0, 64'h0000_0000_8000_0000, '0, 0, 0, 0, 0);
        checks++; if (r_result !== 64'h80) begin errors++; $display("FAIL lbu_data: got %h want 80", r_result); end
    endtask

    task automatic test_word_store;
        run_op(0, 1, 3'b010, 64'h2004, 64'hDEAD_BEEF, '0, '0, 0, 0, 0, 0);
        checks++; if (r_be[0] !== 8'hF0 || r_addr[0] !== 64'h2000 || r_we[0] !== 1'b1) begin errors++; $display("FAIL sw_beat: be %h addr %h we %b want f0 2000 1", r_be[0], r_addr[0], r_we[0]); end
        checks++; if (r_wdata[0] !== 64'hDEAD_BEEF_0000_0000) begin errors++; $display("FAIL sw_wdata: got %h want deadbeef00000000", r_wdata[0]); end
        checks++; if (r_result !== '0 || r_fault !== 1'b0) begin errors++; $display("FAIL sw_result: wr %h fault %b want 0 0", r_result, r_fault); end
        checks++; if (r_cycles !== 3) begin errors++; $display("FAIL sw_latency: got %0d want 3", r_cycles); end
    endtask

    task automatic test_split_dword_load;
        run_op(1, 0, 3'b011, 64'h3006, '0, 64'hBBAA_0000_0000_0000, 64'h0000_FFEE_DDCC_2211, 0, 0, 0, 0);
        checks++; if (r_beats !== 2) begin errors++; $display("FAIL ld_split_beats: got %0d want 2", r_beats); end
        checks++; if (r_addr[0] !== 64'h3000 || r_be[0] !== 8'hC0) begin errors++; $display("FAIL ld_split_b0: addr %h be %h want 3000 c0", r_addr[0], r_be[0]); end
        checks++; if (r_addr[1] !== 64'h3008 || r_be[1] !== 8'h3F) begin errors++; $display("FAIL ld_split_b1: addr %h be %h want 3008 3f", r_addr[1], r_be[1]); end
        checks++; if (r_result !== 64'hFFEE_DDCC_2211_BBAA) begin errors++; $display("FAIL ld_split_data: got %h want ffeeddcc2211bbaa", r_result); end
        checks++; if (r_cycles !== 5) begin errors++; $display("FAIL ld_split_latency: got %0d want 5", r_cycles); end
    endtask

    task automatic test_split_half_load;
        run_op(1, 0, 3'b001, 64'h5007, '0, 64'h8F00_0000_0000_0000, 64'h1234_5678_9ABC_DEFE, 0, 0, 0, 0);
        checks++; if (r_be[0] !== 8'h80 || r_be[1] !== 8'h01 || r_addr[1] !== 64'h5008) begin errors++; $display("FAIL lh_split_beats: be0 %h be1 %h addr1 %h want 80 01 5008", r_be[0], r_be[1], r_addr[1]); end
        checks++; if (r_result !== 64'hFFFF_FFFF_FFFF_FE8F) begin errors++; $display("FAIL lh_split_data: got %h want fffffffffffffe8f", r_result); end
    endtask

    task automatic test_wait_states;
        run_op(1, 0, 3'b110, 64'h6004, '0, 64'h8765_4321_0000_0000, '0, 2, 1, 0, 0);
        checks++; if (r_result !== 64'h0000_0000_8765_4321) begin errors++; $display("FAIL lwu_data: got %h want 0000000087654321", r_result); end
        checks++; if (r_cycles !== 6) begin errors++; $display("FAIL wait_latency: got %0d want 6", r_cycles); end
        run_op(1, 0, 3'b010, 64'h6004, '0, 64'h8765_4321_0000_0000, '0, 0, 0, 0, 0);
        checks++; if (r_result !== 64'hFFFF_FFFF_8765_4321) begin errors++; $display("FAIL lw_data: got %h want ffffffff87654321", r_result); end
        run_op(1, 0, 3'b111, 64'h7000, '0, 64'h8000_0000_0000_0001, '0, 0, 0, 0, 0);
        checks++; if (r_result !== 64'h8000_0000_0000_0001) begin errors++; $display("FAIL ldu_data: got %h want 8000000000000001", r_result); end
    endtask

    task automatic test_split_store_error;
        run_op(0, 1, 3'b011, 64'h4005, 64'h1122_3344_5566_7788, '0, '0, 0, 0, 1, 0);
        checks++; if (r_be[0] !== 8'hE0 || r_wdata[0] !== 64'h6677_8800_0000_0000) begin errors++; $display("FAIL sd_err_b0: be %h wdata %h want e0 6677880000000000", r_be[0], r_wdata[0]); end
        checks++; if (r_beats !== 1) begin errors++; $display("FAIL sd_err_beats: got %0d want 1", r_beats); end
        checks++; if (r_fault !== 1'b1 || r_result !== '0) begin errors++; $display("FAIL sd_err_fault: fault %b wr %h want 1 0", r_fault, r_result); end
        checks++; if (r_cycles !== 3) begin errors++; $display("FAIL sd_err_latency: got %0d want 3", r_cycles); end
    endtask

    task automatic test_timeout;
        run_op(1, 0, 3'b011, 64'h8000, '0, 64'h55, '0, 0, 0, 0, 1);
        checks++; if (r_cycles !== int'(TMO) + 2) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", r_cycles, TMO + 2); end
        checks++; if (r_fault !== 1'b1 || r_result !== '0) begin errors++; $display("FAIL timeout_fault: fault %b wr %h want 1 0", r_fault, r_result); end
    endtask

    task automatic test_reset_mid_req;
        valid_in = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; width = 3'b011; alu_result = 64'h9000;
        @(posedge clk);
        #1 valid_in = 1'b0;
        @(negedge clk);
        checks++; if (req !== 1'b1 || ready_out !== 1'b0) begin errors++; $display("FAIL mid_req_busy: req %b ready %b want 1 0", req, ready_out); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (req !== 1'b0 || addr !== '0) begin errors++; $display("FAIL mid_req_drop: req %b addr %h want 0 0", req, addr); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (ready_out !== 1'b1 || valid_out !== 1'b0) begin errors++; $display("FAIL mid_req_recover: ready %b valid %b want 1 0", ready_out, valid_out); end
        run_op(0, 0, 3'd0, 64'hCAFE, '0, '0, '0, 0, 0, 0, 0);
        checks++; if (r_result !== 64'hCAFE || r_cycles !== 1) begin errors++; $display("FAIL mid_req_after: wr %h cycles %0d want cafe 1", r_result, r_cycles); end
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; width = '0;
        alu_result = '0; rs2 = '0; gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = '0;
        test_reset;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_alu_passthrough;
        test_byte_loads;
        test_word_store;
        test_split_dword_load;
        test_split_half_load;
        test_wait_states;
        test_split_store_error;
        test_timeout;
        test_reset_mid_req;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
